// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, letter indices, A-H code table and 7-segment glyphs.
package morse_pkg;

    typedef enum logic [1:0] {IDLE, MARK, SPACE, DONE} state_t;

    localparam logic [2:0] LTR_A = 3'd0;
    localparam logic [2:0] LTR_B = 3'd1;
    localparam logic [2:0] LTR_C = 3'd2;
    localparam logic [2:0] LTR_D = 3'd3;
    localparam logic [2:0] LTR_E = 3'd4;
    localparam logic [2:0] LTR_F = 3'd5;
    localparam logic [2:0] LTR_G = 3'd6;
    localparam logic [2:0] LTR_H = 3'd7;

    localparam int unsigned DASH_MIN_DEF = 3;
    localparam int unsigned GAP_MIN_DEF  = 3;

    // Element count and pattern per letter; last element in the LSB, 1 = dash.
    localparam logic [2:0] CODE_NE [8] = '{3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4};
    localparam logic [3:0] CODE_ELEM [8] = '{4'b0001, 4'b1000, 4'b1010, 4'b0100,
                                             4'b0000, 4'b0010, 4'b0110, 4'b0000};

    // Active-low segments {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH [8] = '{7'h08, 7'h03, 7'h46, 7'h21,
                                         7'h06, 7'h0E, 7'h42, 7'h09};
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    // Returns {hit, index}.
    function automatic logic [3:0] code_lookup(input logic [2:0] ne, input logic [3:0] elem);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            if (ne == CODE_NE[i] && elem == CODE_ELEM[i]) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Unit-tick rate divider: one-clock tick every TICK_DIV clocks.
module morse_tick_gen #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned CNT_W    = 28
) (
    input  logic clock,
    input  logic resetn,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/morse_code_decoder.sv
// Morse receiver for letters A-H; samples the key once per unit tick.
// Optional MORSE_DEC_HEX_EN adds a registered active-low 7-segment output.
module morse_code_decoder
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned CNT_W    = 28,
    parameter int unsigned DASH_MIN = DASH_MIN_DEF,
    parameter int unsigned GAP_MIN  = GAP_MIN_DEF
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       error,
    output logic       busy
`ifdef MORSE_DEC_HEX_EN
    ,
    output logic [6:0] hex
`endif
);

    localparam logic [2:0] DASH_MIN_R = 3'(DASH_MIN);
    localparam logic [2:0] GAP_MIN_R  = 3'(GAP_MIN);

    logic       sync1_q, samp;
    logic       tick;
    state_t     state_q, state_d;
    logic [2:0] run_q, run_d, run_inc;
    logic [3:0] elem_q, elem_d;
    logic [2:0] ne_q, ne_d;
    logic       ovf_q, ovf_d;
    logic [2:0] letter_q, letter_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic [3:0] lookup;

    morse_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clock  (clock),
        .resetn (resetn),
        .tick   (tick)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            samp    <= 1'b0;
        end else begin
            sync1_q <= key_in;
            samp    <= sync1_q;
        end
    end

    assign run_inc = run_q + 3'd1;
    assign lookup  = code_lookup(ne_q, elem_q);

    // The lookup is registered on the tick that enters DONE, so the pulse lines up with DONE.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        elem_d   = elem_q;
        ne_d     = ne_q;
        ovf_d    = ovf_q;
        letter_d = letter_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick && samp) begin
                    state_d = MARK;
                    run_d   = 3'd1;
                    elem_d  = 4'd0;
                    ne_d    = 3'd0;
                    ovf_d   = 1'b0;
                end
            end
            MARK: begin
                if (tick) begin
                    if (samp) begin
                        if (run_q != 3'd7) begin
                            run_d = run_inc;
                        end
                    end else begin
                        if (ne_q == 3'd4) begin
                            ovf_d = 1'b1;
                        end else begin
                            elem_d = {elem_q[2:0], (run_q >= DASH_MIN_R)};
                            ne_d   = ne_q + 3'd1;
                        end
                        state_d = SPACE;
                        run_d   = 3'd1;
                    end
                end
            end
            SPACE: begin
                if (tick) begin
                    if (samp) begin
                        state_d = MARK;
                        run_d   = 3'd1;
                    end else begin
                        run_d = run_inc;
                        if (run_inc >= GAP_MIN_R) begin
                            state_d = DONE;
                            if (lookup[3] && !ovf_q) begin
                                valid_d  = 1'b1;
                                letter_d = lookup[2:0];
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            run_q    <= 3'd0;
            elem_q   <= 4'd0;
            ne_q     <= 3'd0;
            ovf_q    <= 1'b0;
            letter_q <= 3'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            elem_q   <= elem_d;
            ne_q     <= ne_d;
            ovf_q    <= ovf_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign letter       = letter_q;
    assign letter_valid = valid_q;
    assign error        = error_q;
    assign busy         = (state_q != IDLE);

`ifdef MORSE_DEC_HEX_EN
    logic [6:0] hex_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hex_q <= GLYPH_BLANK;
        end else if (valid_q) begin
            hex_q <= GLYPH[letter_q];
        end else if (error_q) begin
            hex_q <= GLYPH_BLANK;
        end
    end

    assign hex = hex_q;
`endif

endmodule
